// File: rtl/coherent_bus_ctrl.sv
// rtl/coherent_bus_ctrl.sv - two-core coherent memory bus controller with MSI snooping
//
// Sits between two dcache/icache pairs and a single-ported RAM. Arbitrates
// requests (dcache over icache, round-robin between cores), snoops the other
// dcache on coherent reads/upgrades, and writes a dirty snooped block back to
// RAM before serving the requester's read from RAM.
//
// Ports:
//   CLK, nRST             clock, asynchronous active-low reset
//   iREN/iaddr            icache read request and address, per core
//   iwait/iload           icache wait (low = beat complete) and read data
//   dREN/dWEN/cctrans     dcache read, writeback, coherent transaction flag
//   daddr/dstore          dcache address and write/snoop data
//   dwait/dload           dcache wait (low = beat complete) and read data
//   ccwrite               snooped cache holds the block dirty
//   ccwait/ccinv          snoop in progress / invalidate, to the snooped cache
//   ccsnoopaddr           snoop block address
//   ramREN/ramWEN         RAM read/write strobes
//   ramaddr/ramstore      RAM address and write data
//   ramload/ram_wait      RAM read data and not-ready flag
module coherent_bus_ctrl #(
   parameter int CPUS   = 2,
   parameter int WORD_W = 32
) (
   input  logic                          CLK,
   input  logic                          nRST,
   input  logic [CPUS-1:0]               iREN,
   input  logic [CPUS-1:0][WORD_W-1:0]   iaddr,
   output logic [CPUS-1:0]               iwait,
   output logic [CPUS-1:0][WORD_W-1:0]   iload,
   input  logic [CPUS-1:0]               dREN,
   input  logic [CPUS-1:0]               dWEN,
   input  logic [CPUS-1:0]               cctrans,
   input  logic [CPUS-1:0][WORD_W-1:0]   daddr,
   input  logic [CPUS-1:0][WORD_W-1:0]   dstore,
   output logic [CPUS-1:0]               dwait,
   output logic [CPUS-1:0][WORD_W-1:0]   dload,
   input  logic [CPUS-1:0]               ccwrite,
   output logic [CPUS-1:0]               ccwait,
   output logic [CPUS-1:0]               ccinv,
   output logic [CPUS-1:0][WORD_W-1:0]   ccsnoopaddr,
   output logic                          ramREN,
   output logic                          ramWEN,
   output logic [WORD_W-1:0]             ramaddr,
   output logic [WORD_W-1:0]             ramstore,
   input  logic [WORD_W-1:0]             ramload,
   input  logic                          ram_wait
);

   typedef enum logic [2:0] {
      IDLE, WB, SNOOP, SNRESP, C2C0, C2C1, RAMRD, IFETCH
   } state_t;

   state_t state_q, state_d;
   logic   rr_q, rr_d;
   logic   req_q, req_d;
   logic   excl_q, excl_d;
   logic   upg_q, upg_d;

   logic              snp;
   logic              win;
   logic [CPUS-1:0]   dreq;
   logic [WORD_W-1:0] base;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
         req_q   <= 1'b0;
         excl_q  <= 1'b0;
         upg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         req_q   <= req_d;
         excl_q  <= excl_d;
         upg_q   <= upg_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      req_d       = req_q;
      excl_d      = excl_q;
      upg_d       = upg_q;
      win         = rr_q;
      iwait       = '1;
      dwait       = '1;
      ccwait      = '0;
      ccinv       = '0;
      ccsnoopaddr = '0;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;
      iload       = {CPUS{ramload}};
      dload       = {CPUS{ramload}};

      snp  = ~req_q;
      dreq = dREN | dWEN | cctrans;
      // Snoops and cache-to-RAM flushes work on whole two-word blocks.
      base = {daddr[req_q][WORD_W-1:3], 3'b000};

      case (state_q)
         IDLE: begin
            if (|dreq) begin
               win    = dreq[rr_q] ? rr_q : ~rr_q;
               req_d  = win;
               excl_d = cctrans[win];
               upg_d  = cctrans[win] & ~dREN[win] & ~dWEN[win];
               state_d = (dWEN[win] && !cctrans[win]) ? WB : SNOOP;
            end else if (|iREN) begin
               win     = iREN[rr_q] ? rr_q : ~rr_q;
               req_d   = win;
               state_d = IFETCH;
            end
         end
         WB: begin
            if (dWEN[req_q]) begin
               ramWEN       = 1'b1;
               ramaddr      = daddr[req_q];
               ramstore     = dstore[req_q];
               dwait[req_q] = ram_wait;
            end else begin
               state_d = IDLE;
            end
         end
         SNOOP, SNRESP: begin
            ccwait[snp]      = 1'b1;
            ccinv[snp]       = excl_q;
            ccsnoopaddr[snp] = base;
            if (state_q == SNOOP) begin
               state_d = SNRESP;
            end else if (upg_q) begin
               // An upgrade only needs the invalidate; no data moves.
               dwait[req_q] = 1'b0;
               state_d      = IDLE;
            end else if (ccwrite[snp]) begin
               state_d = C2C0;
            end else begin
               state_d = RAMRD;
            end
         end
         C2C0, C2C1: begin
            ccwait[snp]  = 1'b1;
            ramWEN       = 1'b1;
            ramaddr      = (state_q == C2C0) ? base : base + WORD_W'(4);
            ramstore     = dstore[snp];
            dwait[snp]   = ram_wait;
            if (!ram_wait) begin
               state_d = (state_q == C2C0) ? C2C1 : RAMRD;
            end
         end
         RAMRD: begin
            if (dREN[req_q]) begin
               ramREN       = 1'b1;
               ramaddr      = daddr[req_q];
               dwait[req_q] = ram_wait;
            end else begin
               state_d = IDLE;
            end
         end
         IFETCH: begin
            ramREN       = 1'b1;
            ramaddr      = iaddr[req_q];
            iwait[req_q] = ram_wait;
            if (!ram_wait) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Hand priority to the other core once the current transaction ends.
      if (state_q != IDLE && state_d == IDLE) begin
         rr_d = ~req_q;
      end
   end

endmodule

// File: tb/tb_coherent_bus_ctrl.sv
// tb/tb_coherent_bus_ctrl.sv - directed self-checking bench for coherent_bus_ctrl
module tb_coherent_bus_ctrl;

   logic              CLK;
   logic              nRST;
   logic [1:0]        iREN;
   logic [1:0][31:0]  iaddr;
   logic [1:0]        iwait;
   logic [1:0][31:0]  iload;
   logic [1:0]        dREN;
   logic [1:0]        dWEN;
   logic [1:0]        cctrans;
   logic [1:0][31:0]  daddr;
   logic [1:0][31:0]  dstore;
   logic [1:0]        dwait;
   logic [1:0][31:0]  dload;
   logic [1:0]        ccwrite;
   logic [1:0]        ccwait;
   logic [1:0]        ccinv;
   logic [1:0][31:0]  ccsnoopaddr;
   logic              ramREN;
   logic              ramWEN;
   logic [31:0]       ramaddr;
   logic [31:0]       ramstore;
   logic [31:0]       ramload;
   logic              ram_wait;

   logic [31:0] mem [0:255];
   int          n_chk;
   int          n_fail;
   int          n_ram;
   int          ram_snap;

   coherent_bus_ctrl dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .cctrans(cctrans), .daddr(daddr),
      .dstore(dstore), .dwait(dwait), .dload(dload),
      .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ram_wait(ram_wait)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   assign ramload = mem[ramaddr[9:2]];

   always @(posedge CLK) begin
      if (ramWEN && !ram_wait) mem[ramaddr[9:2]] <= ramstore;
      if (ramREN || ramWEN) n_ram++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   always @(negedge CLK) begin
      if (nRST) check("ren_wen_excl", {31'b0, ramREN & ramWEN}, 32'd0);
   end

   initial begin
      n_chk = 0; n_fail = 0; n_ram = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + i;
      nRST = 1'b0; ram_wait = 1'b0;
      iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; cctrans = '0;
      daddr = '0; dstore = '0; ccwrite = '0;
      repeat (2) @(negedge CLK);

      // reset defaults
      check("rst_iwait", {30'b0, iwait}, 32'd3);
      check("rst_dwait", {30'b0, dwait}, 32'd3);
      check("rst_ccwait", {30'b0, ccwait}, 32'd0);
      check("rst_ccinv", {30'b0, ccinv}, 32'd0);
      check("rst_snpaddr1", ccsnoopaddr[1], 32'd0);
      check("rst_ren", {31'b0, ramREN}, 32'd0);
      check("rst_wen", {31'b0, ramWEN}, 32'd0);
      check("rst_ramaddr", ramaddr, 32'd0);
      check("rst_iload0", iload[0], 32'h1000);
      nRST = 1'b1;

      // core0 shared read 0x100, other cache clean
      dREN = 2'b01; daddr[0] = 32'h100;
      tick();
      check("t1_snoop_ccwait", {30'b0, ccwait}, 32'd2);
      check("t1_snoop_ccinv", {30'b0, ccinv}, 32'd0);
      check("t1_snoop_addr", ccsnoopaddr[1], 32'h100);
      check("t1_snoop_dwait", {30'b0, dwait}, 32'd3);
      tick();
      check("t1_snresp_ccwait", {30'b0, ccwait}, 32'd2);
      tick();
      check("t1_rd_ren", {31'b0, ramREN}, 32'd1);
      check("t1_rd_addr", ramaddr, 32'h100);
      check("t1_rd_data0", dload[0], 32'h1040);
      check("t1_rd_dwait", {30'b0, dwait}, 32'd2);
      check("t1_rd_ccinv", {30'b0, ccinv}, 32'd0);
      tick();
      daddr[0] = 32'h104; #1;
      check("t1_rd_data1", dload[0], 32'h1041);
      check("t1_rd_dwait1", {30'b0, dwait}, 32'd2);
      tick();
      dREN = 2'b00; #1;
      check("t1_end_ren", {31'b0, ramREN}, 32'd0);
      check("t1_end_dwait", {30'b0, dwait}, 32'd3);
      tick();

      // core1 dirty at 0x200, core0 read-exclusive 0x204
      dREN = 2'b01; cctrans = 2'b01; daddr[0] = 32'h204;
      tick();
      check("t2_snoop_ccwait", {30'b0, ccwait}, 32'd2);
      check("t2_snoop_ccinv", {30'b0, ccinv}, 32'd2);
      check("t2_snoop_addr1", ccsnoopaddr[1], 32'h200);
      check("t2_snoop_addr0", ccsnoopaddr[0], 32'h0);
      ccwrite = 2'b10;
      tick();
      check("t2_snresp_ccinv", {30'b0, ccinv}, 32'd2);
      tick();
      dstore[1] = 32'hAA; #1;
      check("t2_c2c0_wen", {31'b0, ramWEN}, 32'd1);
      check("t2_c2c0_addr", ramaddr, 32'h200);
      check("t2_c2c0_data", ramstore, 32'hAA);
      check("t2_c2c0_dwait", {30'b0, dwait}, 32'd1);
      check("t2_c2c0_ccwait", {30'b0, ccwait}, 32'd2);
      tick();
      dstore[1] = 32'hBB; #1;
      check("t2_c2c1_addr", ramaddr, 32'h204);
      check("t2_c2c1_data", ramstore, 32'hBB);
      check("t2_c2c1_dwait", {30'b0, dwait}, 32'd1);
      tick();
      ccwrite = 2'b00; #1;
      check("t2_mem200", mem[8'h80], 32'hAA);
      check("t2_mem204", mem[8'h81], 32'hBB);
      check("t2_rd_ren", {31'b0, ramREN}, 32'd1);
      check("t2_rd_data", dload[0], 32'hBB);
      check("t2_rd_dwait", {30'b0, dwait}, 32'd2);
      check("t2_rd_ccwait", {30'b0, ccwait}, 32'd0);
      tick();
      dREN = 2'b00; cctrans = 2'b00;
      tick();

      // core0 upgrade 0x300
      ram_snap = n_ram;
      cctrans = 2'b01; daddr[0] = 32'h300;
      tick();
      check("t3_snoop_ccwait", {30'b0, ccwait}, 32'd2);
      check("t3_snoop_ccinv", {30'b0, ccinv}, 32'd2);
      check("t3_snoop_dwait", {30'b0, dwait}, 32'd3);
      tick();
      check("t3_snresp_ccwait", {30'b0, ccwait}, 32'd2);
      check("t3_snresp_ccinv", {30'b0, ccinv}, 32'd2);
      check("t3_snresp_dwait", {30'b0, dwait}, 32'd2);
      cctrans = 2'b00;
      tick();
      check("t3_idle_ccwait", {30'b0, ccwait}, 32'd0);
      check("t3_idle_dwait", {30'b0, dwait}, 32'd3);
      check("t3_no_ram", n_ram - ram_snap, 32'd0);

      // reset during C2C0
      dREN = 2'b01; cctrans = 2'b01; daddr[0] = 32'h040;
      tick();
      ccwrite = 2'b10;
      tick();
      tick();
      dstore[1] = 32'hDEAD; #1;
      check("t6_c2c0_wen", {31'b0, ramWEN}, 32'd1);
      check("t6_c2c0_addr", ramaddr, 32'h040);
      nRST = 1'b0; #1;
      check("t6_rst_wen", {31'b0, ramWEN}, 32'd0);
      check("t6_rst_addr", ramaddr, 32'd0);
      check("t6_rst_ccwait", {30'b0, ccwait}, 32'd0);
      check("t6_rst_dwait", {30'b0, dwait}, 32'd3);
      check("t6_rst_iwait", {30'b0, iwait}, 32'd3);
      dREN = '0; cctrans = '0; ccwrite = '0; dstore = '0;
      tick();
      check("t6_mem_kept", mem[8'h10], 32'h1010);
      nRST = 1'b1;
      tick();
      check("t6_idle_wen", {31'b0, ramWEN}, 32'd0);

      // both cores writeback in the same cycle, rr = 0 after reset
      dWEN = 2'b11; daddr[0] = 32'h080; daddr[1] = 32'h0C0;
      dstore[0] = 32'h11111111; dstore[1] = 32'h22222222;
      tick();
      check("t5_wb0_wen", {31'b0, ramWEN}, 32'd1);
      check("t5_wb0_addr", ramaddr, 32'h080);
      check("t5_wb0_data", ramstore, 32'h11111111);
      check("t5_wb0_dwait", {30'b0, dwait}, 32'd2);
      tick();
      dWEN = 2'b10; #1;
      check("t5_wb0_end_wen", {31'b0, ramWEN}, 32'd0);
      check("t5_wb0_end_dwait", {30'b0, dwait}, 32'd3);
      tick();
      check("t5_idle_dwait", {30'b0, dwait}, 32'd3);
      tick();
      check("t5_wb1_addr", ramaddr, 32'h0C0);
      check("t5_wb1_data", ramstore, 32'h22222222);
      check("t5_wb1_dwait", {30'b0, dwait}, 32'd1);
      tick();
      dWEN = 2'b00;
      tick();
      check("t5_mem080", mem[8'h20], 32'h11111111);
      check("t5_mem0c0", mem[8'h30], 32'h22222222);

      // icache and dcache together: dcache first, then a slow IFETCH
      iREN = 2'b01; iaddr[0] = 32'h104; dREN = 2'b10; daddr[1] = 32'h100;
      tick();
      check("t4_snoop_ccwait", {30'b0, ccwait}, 32'd1);
      check("t4_snoop_iwait", {30'b0, iwait}, 32'd3);
      tick();
      tick();
      check("t4_rd_ren", {31'b0, ramREN}, 32'd1);
      check("t4_rd_addr", ramaddr, 32'h100);
      check("t4_rd_data", dload[1], 32'h1040);
      check("t4_rd_dwait", {30'b0, dwait}, 32'd1);
      check("t4_rd_iwait", {30'b0, iwait}, 32'd3);
      tick();
      dREN = 2'b00;
      tick();
      ram_wait = 1'b1;
      check("t4_idle_iwait", {30'b0, iwait}, 32'd3);
      tick();
      check("t4_if1_ren", {31'b0, ramREN}, 32'd1);
      check("t4_if1_addr", ramaddr, 32'h104);
      check("t4_if1_iwait", {30'b0, iwait}, 32'd3);
      tick();
      check("t4_if2_iwait", {30'b0, iwait}, 32'd3);
      tick();
      check("t4_if3_iwait", {30'b0, iwait}, 32'd3);
      tick();
      ram_wait = 1'b0; #1;
      check("t4_if4_iwait", {30'b0, iwait}, 32'd2);
      check("t4_if4_data", iload[0], 32'h1041);
      tick();
      iREN = 2'b00; #1;
      check("t4_end_iwait", {30'b0, iwait}, 32'd3);
      check("t4_end_ren", {31'b0, ramREN}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/coherent_bus_ctrl.md
Name: coherent_bus_ctrl

Overview:
- Memory-side bus controller that sits directly downstream of two dcache and two icache instances (cores 0 and 1) and drives a single-ported RAM.
- Arbitrates cache requests and runs MSI-style snooping between the two dcaches over the cc* signals.
- On a snoop hit to a dirty block, the snooping cache writes the block back to RAM, and the requester's read is then served from RAM.

Parameters:
- CPUS, 2, number of cores; fixed at 2, and other values are not supported.
- WORD_W, 32, data/address width.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  [1:0]  icache read request, per core
- iaddr  in  2x32  icache address
- iwait  out  [1:0]  icache wait; low marks the beat complete
- iload  out  2x32  icache read data
- dREN  in  [1:0]  dcache read
- dWEN  in  [1:0]  dcache write (writeback)
- cctrans  in  [1:0]  coherent transaction flag
- daddr  in  2x32  dcache address
- dstore  in  2x32  dcache write data; also carries snoop data
- dwait  out  [1:0]  dcache wait; low marks the beat complete
- dload  out  2x32  dcache read data
- ccwrite  in  [1:0]  snooped cache holds the block dirty
- ccwait  out  [1:0]  snoop in progress, addressed to that cache
- ccinv  out  [1:0]  invalidate the snooped block
- ccsnoopaddr  out  2x32  snoop address
- ramREN  out  1  RAM read
- ramWEN  out  1  RAM write
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ram_wait  in  1  RAM not ready this cycle

Behaviour:
- Combinational defaults every cycle:
  - iwait = dwait = 2'b11
  - ccwait = ccinv = 0, ccsnoopaddr = 0
  - ramREN = ramWEN = 0, ramaddr = ramstore = 0
  - iload[i] = dload[i] = ramload
- Reset: state = IDLE, round-robin pointer rr = 0, latched req = 0, excl = 0. A reset mid-transaction abandons it with no partial RAM beat completed.
- Request classes for core i:
  - WB: dWEN & !cctrans.
  - SHRD (shared read): dREN & !cctrans.
  - EXRD (read-exclusive): dREN & cctrans.
  - UPG (upgrade / invalidate only): cctrans & !dREN & !dWEN.
  - IF (instruction fetch): iREN.
- Arbitration in IDLE:
  - Any dcache request beats any icache request.
  - Between the two cores, rr picks the winner: core rr wins if both are requesting.
  - The winner is latched into req; rr <= !req when the transaction returns to IDLE.
  - snp = !req throughout the transaction.
- IDLE transitions:
  - WB → WB.
  - SHRD/EXRD/UPG → SNOOP; excl latched = cctrans[req].
  - IF → IFETCH.
  - No request: stay in IDLE.
- WB:
  - Drives ramWEN = 1, ramaddr = daddr[req], ramstore = dstore[req], dwait[req] = ram_wait.
  - If dWEN[req] == 0, go to IDLE with no RAM access that cycle.
- SNOOP (exactly 1 cycle):
  - Drives ccwait[snp] = 1, ccinv[snp] = excl, ccsnoopaddr[snp] = {daddr[req][31:3], 3'b000}.
  - Next state is SNRESP.
- SNRESP:
  - Holds the same cc outputs and samples ccwrite[snp].
  - UPG: dwait[req] = 0 for this single cycle, then IDLE.
  - Else if ccwrite[snp] is high: go to C2C0.
  - Else: go to RAMRD.
- C2C0:
  - Holds ccwait[snp].
  - Drives ramWEN = 1, ramaddr = block base, ramstore = dstore[snp], dwait[snp] = ram_wait.
  - When !ram_wait, go to C2C1.
- C2C1:
  - Same as C2C0 but with ramaddr = base + 4.
  - When !ram_wait, go to RAMRD.
- RAMRD:
  - Drives ramREN = 1, ramaddr = daddr[req], dload[req] = ramload, dwait[req] = ram_wait.
  - Stays for any number of beats.
  - If dREN[req] == 0, go to IDLE with no RAM access that cycle.
- IFETCH:
  - Drives ramREN = 1, ramaddr = iaddr[req], iwait[req] = ram_wait.
  - Single beat; when !ram_wait, go to IDLE.
- Fairness and invariants:
  - The non-granted core sees wait = 1 for the whole transaction.
  - A cache that is being snooped defers its own request until ccwait drops.
  - ramREN and ramWEN are never both high in the same cycle.
  - ccwait is never high on the requester.
- Simultaneous EXRD from both cores to the same block: served serially in rr order. The second requester snoops the first core's now-dirty copy.

Test Plan:
- Core0 SHRD 0x100, other cache clean, ram_wait low → SNOOP → SNRESP → RAMRD; two beats return RAM[0x100] and RAM[0x104]; ccinv stays 0.
- Core1 holds 0x200 dirty (0xAA, 0xBB); core0 EXRD 0x204 → ccinv[1] = 1; RAM[0x200] = 0xAA and RAM[0x204] = 0xBB are written; then core0 reads 0xBB from 0x204.
- Core0 UPG 0x300 → ccwait[1] held 2 cycles with ccinv[1] = 1; dwait[0] is low exactly 1 cycle; no RAM access occurs.
- iREN[0] and dREN[1] asserted together → the dcache request is served first, then IFETCH; with ram_wait held 3 cycles, iwait[0] falls on the 4th cycle.
- Both cores WB to different addresses in the same cycle with rr = 0 → core0 is served first and rr becomes 1; core1 is then served; both RAM words are correct.
- nRST asserted during C2C0 → all outputs return to defaults immediately; after release, state is IDLE and rr = 0.
